// File: rtl/costas_gear_ctrl.sv
// -----------------------------------------------------------------------------
// costas_gear_ctrl
//
// Loop-bandwidth gear shifter for a Costas carrier-recovery loop. It averages
// |phase error| over windows of 2^WIN_LOG2 accepted samples. From those window
// averages it decides whether the loop is acquiring, narrowing or locked. It
// steps the NCO loop-gain shift (FEEDBACK_SHIFT) between SHIFT_ACQ (wide
// bandwidth) and SHIFT_TRK (narrow bandwidth).
//
// Ports
//   clk_16M384       in   system clock, all logic on the rising edge
//   rst_n_16M384     in   asynchronous active-low reset
//   enable           in   controller run; low returns to IDLE
//   feedback_tdata   in   signed phase-detector error sample (WIDTH bits)
//   feedback_tvalid  in   sample qualifier, no backpressure
//   FEEDBACK_SHIFT   out  registered loop-gain shift for the NCO accumulator
//   shift_upd        out  one-cycle pulse when FEEDBACK_SHIFT changes value
//   locked           out  high only in state LOCKED
//   state            out  IDLE=0, ACQUIRE=1, NARROW=2, LOCKED=3
//   relock_cnt       out  number of LOCKED->ACQUIRE transitions (saturating)
//
// Optional feature macro: COSTAS_GEAR_CTRL_STATS_EN
//   defined   -> relock_cnt counts loss-of-lock events and saturates at 255.
//   undefined -> relock_cnt is tied to 0 and no counter is built.
// -----------------------------------------------------------------------------
module costas_gear_ctrl #(
  parameter int          WIDTH      = 16,
  parameter int          WIN_LOG2   = 10,
  parameter logic [3:0]  SHIFT_ACQ  = 4'd2,
  parameter logic [3:0]  SHIFT_TRK  = 4'd6,
  parameter logic [15:0] LOCK_THR   = 16'd2048,
  parameter logic [15:0] UNLOCK_THR = 16'd4096,
  parameter int          LOCK_CNT   = 3,
  parameter int          LOSS_CNT   = 2
) (
  input  logic                    clk_16M384,
  input  logic                    rst_n_16M384,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] feedback_tdata,
  input  logic                    feedback_tvalid,
  output logic [3:0]              FEEDBACK_SHIFT,
  output logic                    shift_upd,
  output logic                    locked,
  output logic [1:0]              state,
  output logic [7:0]              relock_cnt
);

  localparam int               ACC_W        = WIDTH + WIN_LOG2;
  localparam logic [3:0]       LOCK_CNT_C   = 4'(LOCK_CNT);
  localparam logic [3:0]       LOSS_CNT_C   = 4'(LOSS_CNT);
  localparam logic [ACC_W-1:0] LOCK_THR_W   = ACC_W'(LOCK_THR);
  localparam logic [ACC_W-1:0] UNLOCK_THR_W = ACC_W'(UNLOCK_THR);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    NARROW  = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  // Magnitude of a signed sample. The most negative code has no positive
  // counterpart, so it saturates to the largest positive magnitude.
  function automatic logic [WIDTH-2:0] sat_abs(input logic signed [WIDTH-1:0] x);
    logic signed [WIDTH-1:0] neg;
    neg = -x;
    if (x[WIDTH-1] && (x[WIDTH-2:0] == '0)) begin
      sat_abs = '1;
    end else if (x[WIDTH-1]) begin
      sat_abs = neg[WIDTH-2:0];
    end else begin
      sat_abs = x[WIDTH-2:0];
    end
  endfunction

  state_t               state_q, state_d;
  logic [3:0]           shift_q, shift_d;
  logic                 upd_q, upd_d;
  logic [3:0]           good_q, good_d;
  logic [3:0]           bad_q, bad_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [WIN_LOG2-1:0]  samp_q, samp_d;

  logic [ACC_W-1:0]     mag_ext;
  logic [ACC_W-1:0]     sum_now;
  logic [ACC_W-1:0]     avg;
  logic                 win_close;
  logic                 win_good;
  logic                 win_bad;

  // The closing sample is included in its own window average.
  assign mag_ext   = {{(WIN_LOG2+1){1'b0}}, sat_abs(feedback_tdata)};
  assign sum_now   = acc_q + mag_ext;
  assign avg       = sum_now >> WIN_LOG2;
  assign win_close = feedback_tvalid && (samp_q == '1);
  assign win_good  = (avg < LOCK_THR_W);
  assign win_bad   = (avg >= UNLOCK_THR_W);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    good_d  = good_q;
    bad_d   = bad_q;
    acc_d   = acc_q;
    samp_d  = samp_q;

    if (!enable || (state_q == IDLE)) begin
      // Dropping enable wins over a window closing in the same cycle.
      state_d = enable ? ACQUIRE : IDLE;
      shift_d = SHIFT_ACQ;
      good_d  = '0;
      bad_d   = '0;
      acc_d   = '0;
      samp_d  = '0;
    end else begin
      if (feedback_tvalid) begin
        samp_d = samp_q + 1'b1;
        acc_d  = win_close ? '0 : sum_now;
      end

      if (win_close) begin
        case (state_q)
          ACQUIRE: begin
            if (win_good) begin
              if ((good_q + 4'd1) == LOCK_CNT_C) begin
                good_d  = '0;
                bad_d   = '0;
                shift_d = SHIFT_ACQ + 4'd1;
                // With a single gear step the loop is already fully narrowed.
                state_d = ((SHIFT_ACQ + 4'd1) == SHIFT_TRK) ? LOCKED : NARROW;
              end else begin
                good_d = good_q + 4'd1;
              end
            end else if (win_bad) begin
              good_d = '0;
            end
          end
          NARROW: begin
            if (win_good) begin
              shift_d = shift_q + 4'd1;
              if ((shift_q + 4'd1) == SHIFT_TRK) begin
                state_d = LOCKED;
                bad_d   = '0;
              end
            end else if (win_bad) begin
              state_d = ACQUIRE;
              shift_d = SHIFT_ACQ;
              good_d  = '0;
            end
          end
          LOCKED: begin
            if (win_bad) begin
              if ((bad_q + 4'd1) == LOSS_CNT_C) begin
                state_d = ACQUIRE;
                shift_d = SHIFT_ACQ;
                good_d  = '0;
                bad_d   = '0;
              end else begin
                bad_d = bad_q + 4'd1;
              end
            end else if (win_good) begin
              bad_d = '0;
            end
          end
          default: ;
        endcase
      end
    end

    upd_d = (shift_d != shift_q);
  end

  always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
    if (!rst_n_16M384) begin
      state_q <= IDLE;
      shift_q <= SHIFT_ACQ;
      upd_q   <= 1'b0;
      good_q  <= '0;
      bad_q   <= '0;
      acc_q   <= '0;
      samp_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      upd_q   <= upd_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      acc_q   <= acc_d;
      samp_q  <= samp_d;
    end
  end

  assign FEEDBACK_SHIFT = shift_q;
  assign shift_upd      = upd_q;
  assign locked         = (state_q == LOCKED);
  assign state          = state_q;

`ifdef COSTAS_GEAR_CTRL_STATS_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] relock_q, relock_d;

  always_comb begin
    relock_d = relock_q;
    if ((state_q == LOCKED) && (state_d == ACQUIRE)) begin
      relock_d = sat_inc8(relock_q);
    end
  end

  always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
    if (!rst_n_16M384) begin
      relock_q <= 8'd0;
    end else begin
      relock_q <= relock_d;
    end
  end

  assign relock_cnt = relock_q;
`else
  assign relock_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_costas_gear_ctrl.sv
// -----------------------------------------------------------------------------
// tb_costas_gear_ctrl
//
// Bench for costas_gear_ctrl with WIN_LOG2=4 (16-sample windows), LOCK_CNT=3,
// LOSS_CNT=2, SHIFT_ACQ=2, SHIFT_TRK=6. A window-level reference model
// (sample queue, average by division) tracks the expected outputs every
// cycle. A table of window sequences and a few hand-written corner sequences
// add directed checks.
// -----------------------------------------------------------------------------
module tb_costas_gear_ctrl;

`ifdef COSTAS_GEAR_CTRL_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  localparam int WIN = 16;
  localparam int S_ACQ = 2;
  localparam int S_TRK = 6;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic               tv = 1'b0;
  logic signed [15:0] td = '0;

  logic [3:0] fb_shift;
  logic       shift_upd;
  logic       locked;
  logic [1:0] state;
  logic [7:0] relock_cnt;

  costas_gear_ctrl #(
    .WIDTH      (16),
    .WIN_LOG2   (4),
    .SHIFT_ACQ  (4'd2),
    .SHIFT_TRK  (4'd6),
    .LOCK_THR   (16'd2048),
    .UNLOCK_THR (16'd4096),
    .LOCK_CNT   (3),
    .LOSS_CNT   (2)
  ) dut (
    .clk_16M384      (clk),
    .rst_n_16M384    (rst_n),
    .enable          (en),
    .feedback_tdata  (td),
    .feedback_tvalid (tv),
    .FEEDBACK_SHIFT  (fb_shift),
    .shift_upd       (shift_upd),
    .locked          (locked),
    .state           (state),
    .relock_cnt      (relock_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int upd_seen = 0;
  int cyc = 0;

  // Reference model: mode 0..3 as in the state encoding, gear = shift value.
  int m_mode, m_gear, m_good, m_bad, m_relock;
  bit m_upd;
  int win_q[$];

  function automatic void model_reset();
    m_mode = 0; m_gear = S_ACQ; m_good = 0; m_bad = 0; m_relock = 0; m_upd = 0;
    win_q.delete();
  endfunction

  function automatic void model_step();
    int prev_gear, v, mag, sum, a;
    if (!rst_n) begin
      model_reset();
      return;
    end
    prev_gear = m_gear;
    if (!en) begin
      m_mode = 0; m_gear = S_ACQ; m_good = 0; m_bad = 0;
      win_q.delete();
    end else if (m_mode == 0) begin
      m_mode = 1;
      win_q.delete();
    end else if (tv) begin
      v = td;
      mag = (v == -32768) ? 32767 : ((v < 0) ? -v : v);
      win_q.push_back(mag);
      if (win_q.size() == WIN) begin
        sum = 0;
        foreach (win_q[k]) sum += win_q[k];
        a = sum / WIN;
        win_q.delete();
        if (a < 2048) begin
          if (m_mode == 1) begin
            m_good++;
            if (m_good == 3) begin
              m_good = 0;
              m_gear = S_ACQ + 1;
              m_mode = (m_gear == S_TRK) ? 3 : 2;
              m_bad = 0;
            end
          end else if (m_mode == 2) begin
            m_gear++;
            if (m_gear == S_TRK) begin m_mode = 3; m_bad = 0; end
          end else begin
            m_bad = 0;
          end
        end else if (a >= 4096) begin
          if (m_mode == 1) begin
            m_good = 0;
          end else if (m_mode == 2) begin
            m_mode = 1; m_gear = S_ACQ; m_good = 0;
          end else begin
            m_bad++;
            if (m_bad == 2) begin
              m_mode = 1; m_gear = S_ACQ; m_good = 0; m_bad = 0;
              if (STATS != 0 && m_relock < 255) m_relock++;
            end
          end
        end
      end
    end
    m_upd = (m_gear != prev_gear);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic [15:0] act, exp;
    act = {state, fb_shift, shift_upd, locked, relock_cnt};
    exp = {2'(m_mode), 4'(m_gear), m_upd, (m_mode == 3), 8'(m_relock)};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL model cycle %0d: got st=%0d sh=%0d upd=%0d lk=%0d rl=%0d, expected st=%0d sh=%0d upd=%0d lk=%0d rl=%0d",
               cyc, act[15:14], act[13:10], act[9], act[8], act[7:0],
               exp[15:14], exp[13:10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // Inputs are set by the caller just after a falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    if (shift_upd === 1'b1) upd_seen++;
    check_model();
  endtask

  task automatic run_windows(input int err, input int n);
    td = 16'(err);
    tv = 1'b1;
    repeat (WIN * n) cycle();
  endtask

  typedef struct {
    int err;
    int nwin;
    int e_state;
    int e_shift;
    int e_locked;
    int e_relock;
  } vec_t;

  vec_t tbl[15];
  int   vals[12];

  initial begin
    tbl[0]  = '{100,    2, 1, 2, 0, 0};
    tbl[1]  = '{100,    1, 2, 3, 0, 0};
    tbl[2]  = '{100,    1, 2, 4, 0, 0};
    tbl[3]  = '{3000,   1, 2, 4, 0, 0};
    tbl[4]  = '{100,    1, 2, 5, 0, 0};
    tbl[5]  = '{100,    1, 3, 6, 1, 0};
    tbl[6]  = '{5000,   1, 3, 6, 1, 0};
    tbl[7]  = '{100,    1, 3, 6, 1, 0};
    tbl[8]  = '{5000,   1, 3, 6, 1, 0};
    tbl[9]  = '{100,    1, 3, 6, 1, 0};
    tbl[10] = '{5000,   2, 1, 2, 0, STATS};
    tbl[11] = '{-32768, 1, 1, 2, 0, STATS};
    tbl[12] = '{100,    2, 1, 2, 0, STATS};
    tbl[13] = '{-32768, 1, 1, 2, 0, STATS};
    tbl[14] = '{100,    2, 1, 2, 0, STATS};
    vals = '{0, 100, 2047, 2048, 3000, 4095, 4096, 5000, -100, -2048, -4096, -32768};

    model_reset();

    // Reset state
    rst_n = 1'b0; en = 1'b0; tv = 1'b0; td = '0;
    repeat (3) cycle();
    check("rst_state", state, 0);
    check("rst_shift", fb_shift, S_ACQ);
    check("rst_upd", shift_upd, 0);
    check("rst_locked", locked, 0);
    check("rst_relock", relock_cnt, 0);

    // Release and enable: IDLE -> ACQUIRE after one cycle
    rst_n = 1'b1; en = 1'b1;
    cycle();
    check("enter_acquire", state, 1);

    // Table of window sequences
    upd_seen = 0;
    for (int i = 0; i < 15; i++) begin
      run_windows(tbl[i].err, tbl[i].nwin);
      check($sformatf("tbl%0d_state", i), state, tbl[i].e_state);
      check($sformatf("tbl%0d_shift", i), fb_shift, tbl[i].e_shift);
      check($sformatf("tbl%0d_locked", i), locked, tbl[i].e_locked);
      check($sformatf("tbl%0d_relock", i), relock_cnt, tbl[i].e_relock);
      if (i == 5) check("upd_pulses_to_lock", upd_seen, 4);
    end

    // tvalid toggling: the window closes on the 16th valid sample (cycle 31)
    td = 16'sd100;
    for (int i = 0; i < 32; i++) begin
      tv = (i % 2 == 0);
      cycle();
      if (i == 29) check("toggle_before_close", state, 1);
      if (i == 30) begin
        check("toggle_close_state", state, 2);
        check("toggle_close_shift", fb_shift, 3);
      end
    end

    // enable low from NARROW returns to IDLE with a shift update
    en = 1'b0; tv = 1'b0;
    cycle();
    check("disable_state", state, 0);
    check("disable_shift", fb_shift, S_ACQ);
    check("disable_upd", shift_upd, 1);

    // enable dropped exactly when window 3 closes in ACQUIRE
    en = 1'b1;
    cycle();
    run_windows(100, 2);
    repeat (WIN - 1) cycle();
    en = 1'b0;
    cycle();
    check("drop_at_close_state", state, 0);
    check("drop_at_close_shift", fb_shift, S_ACQ);
    check("drop_at_close_upd", shift_upd, 0);
    cycle();
    check("drop_at_close_still_idle", state, 0);

    // Reach LOCKED, then pulse reset mid-cycle
    en = 1'b1;
    cycle();
    run_windows(100, 6);
    check("relock_locked", locked, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_shift", fb_shift, S_ACQ);
    check("async_rst_upd", shift_upd, 0);
    check("async_rst_locked", locked, 0);
    check("async_rst_relock", relock_cnt, 0);
    model_reset();
    cycle();
    rst_n = 1'b1;
    cycle();
    run_windows(100, 3);
    check("post_rst_narrow", state, 2);

    // Randomized traffic against the model
    begin
      int seg_left = 0;
      int seg_val = 0;
      bit seg_rand = 0;
      for (int i = 0; i < 4000; i++) begin
        if (seg_left == 0) begin
          seg_left = $urandom_range(16, 48);
          seg_val  = vals[$urandom_range(0, 11)];
          seg_rand = ($urandom_range(0, 4) == 0);
        end
        seg_left--;
        rst_n = ($urandom_range(0, 1499) != 0);
        en    = ($urandom_range(0, 499) != 0);
        tv    = ($urandom_range(0, 3) != 0);
        td    = seg_rand ? 16'($urandom_range(0, 65535)) : 16'(seg_val);
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/costas_gear_ctrl.md
COSTAS_GEAR_CTRL -- requirements
Module: costas_gear_ctrl

Interface
REQ-001 Parameter WIDTH, 16, bit width of the phase-error sample.
REQ-002 Parameter WIN_LOG2, 10, log2 of the number of valid samples per averaging window.
REQ-003 Parameter SHIFT_ACQ, 4'd2, FEEDBACK_SHIFT used during acquisition (wide loop bandwidth).
REQ-004 Parameter SHIFT_TRK, 4'd6, FEEDBACK_SHIFT used when locked (narrow loop bandwidth); SHIFT_TRK > SHIFT_ACQ.
REQ-005 Parameters LOCK_THR (16'd2048) and UNLOCK_THR (16'd4096), window-average |error| thresholds; LOCK_THR <= UNLOCK_THR.
REQ-006 Parameters LOCK_CNT (3) and LOSS_CNT (2), consecutive-window counts, range 1..15.
REQ-007 clk_16M384  in  1  system clock; one clock, all logic on its rising edge.
REQ-008 rst_n_16M384  in  1  asynchronous, active-low reset.
REQ-009 enable  in  1  controller run; low forces IDLE.
REQ-010 feedback_tdata  in  WIDTH  signed phase-detector error sample, the same stream that drives the NCO phase loop.
REQ-011 feedback_tvalid  in  1  sample qualifier; no backpressure.
REQ-012 FEEDBACK_SHIFT  out  4  registered loop-gain shift for the NCO phase accumulator.
REQ-013 shift_upd  out  1  one-cycle pulse in the cycle FEEDBACK_SHIFT takes a new value.
REQ-014 locked  out  1  high only in state LOCKED.
REQ-015 state  out  2  IDLE=0, ACQUIRE=1, NARROW=2, LOCKED=3.
REQ-016 relock_cnt  out  8  count of LOCKED->ACQUIRE transitions (see Configuration).

Function
REQ-017 Each accepted sample contributes |feedback_tdata| to an accumulator of WIDTH+WIN_LOG2 bits; the most negative input is taken as 2^(WIDTH-1)-1.
REQ-018 A window closes on the 2^WIN_LOG2-th accepted sample; its average (sum >> WIN_LOG2, including that sample) is evaluated in that cycle; state, FEEDBACK_SHIFT, shift_upd and locked reflect the decision from the next cycle on; the accumulator restarts at 0 with no sample lost.
REQ-019 A window is good if avg < LOCK_THR and bad if avg >= UNLOCK_THR; otherwise it is neutral and leaves the consecutive counters unchanged.
REQ-020 IDLE: FEEDBACK_SHIFT=SHIFT_ACQ, accumulator and counters held at 0; enable=1 -> ACQUIRE in the next cycle.
REQ-021 ACQUIRE: a good window increments good_cnt and a bad window clears it; good_cnt reaching LOCK_CNT -> NARROW, with FEEDBACK_SHIFT incremented by 1 and good_cnt cleared.
REQ-022 NARROW: each good window increments FEEDBACK_SHIFT by 1; reaching SHIFT_TRK -> LOCKED; a bad window -> ACQUIRE with FEEDBACK_SHIFT=SHIFT_ACQ.
REQ-023 LOCKED: a bad window increments bad_cnt and a good window clears it; bad_cnt reaching LOSS_CNT -> ACQUIRE with FEEDBACK_SHIFT=SHIFT_ACQ and counters cleared.
REQ-024 shift_upd pulses only when FEEDBACK_SHIFT actually changes value; FEEDBACK_SHIFT never leaves [SHIFT_ACQ, SHIFT_TRK].
REQ-025 enable=0 in any state -> IDLE in the next cycle, with FEEDBACK_SHIFT=SHIFT_ACQ (shift_upd if changed) and the partial window discarded; this takes priority over a window closing in the same cycle.
REQ-026 If SHIFT_ACQ+1 == SHIFT_TRK, the ACQUIRE exit goes directly to LOCKED.

Reset
REQ-027 While rst_n_16M384=0: state=IDLE, FEEDBACK_SHIFT=SHIFT_ACQ, shift_upd=0, locked=0, relock_cnt=0, accumulator and counters 0.
REQ-028 Reset asserted mid-window aborts the window; after release the first window starts at the first accepted sample.

Configuration
REQ-029 With macro COSTAS_GEAR_CTRL_STATS_EN defined, relock_cnt increments on each LOCKED->ACQUIRE transition, saturates at 255, and is cleared only by reset.
REQ-030 Without COSTAS_GEAR_CTRL_STATS_EN, relock_cnt is constant 0 and no counter logic is built.

Verification (WIN_LOG2=4, LOCK_CNT=3, LOSS_CNT=2, SHIFT_ACQ=2, SHIFT_TRK=6)
REQ-031 enable=1, constant error 100, tvalid always high -> ACQUIRE; FEEDBACK_SHIFT 2->3 after window 3; 4, 5, 6 after windows 4-6; locked=1 after window 6; 4 shift_upd pulses in total.
REQ-032 Locked, then error 5000 for 2 windows -> ACQUIRE, FEEDBACK_SHIFT=2, locked=0, relock_cnt=1 (macro defined) or 0 (undefined).
REQ-033 Locked, error alternating 5000/100 per window -> bad_cnt never reaches 2; locked stays 1; no shift_upd.
REQ-034 In NARROW at shift 4, one window of error 3000 (neutral) -> FEEDBACK_SHIFT stays 4; the next window of 100 -> 5.
REQ-035 Error -32768 for a full window -> avg 32767, treated as bad; tvalid toggling 1/0 -> window closes after 16 valid samples (32 cycles).
REQ-036 enable dropped in the cycle window 3 closes in ACQUIRE -> IDLE, FEEDBACK_SHIFT=2, no NARROW entry; rst_n_16M384 pulsed low while LOCKED -> all outputs take their reset values immediately.
